// File: rtl/ripple_adder.sv
// ripple_adder: WIDTH-bit ripple-carry adder with carry in/out and a registered result.
// One full-adder cell per bit; the carry chain runs from bit 0 upward with no lookahead.
module ripple_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);
    logic [WIDTH-1:0] s;
    logic             carry;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;

    // Carry is threaded through a single variable so the chain stays one combinational process.
    always_comb begin
        s     = '0;
        carry = Cin;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (A[i] & carry) | (B[i] & carry);
        end
    end

    always_comb begin
        sum_d  = rst ? '0 : s;
        cout_d = rst ? 1'b0 : carry;
    end

    always_ff @(posedge clk) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;
endmodule

// File: tb/tb_ripple_adder.sv
// tb_ripple_adder: directed and exhaustive checks of the 4-bit registered adder.
// Expected {Cout,Sum} values are queued when operands are driven and checked one edge later.
module tb_ripple_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] A, B;
    logic       Cin;
    logic [3:0] Sum;
    logic       Cout;
    logic [4:0] sb[$];
    int         checks = 0;
    int         errors = 0;

    ripple_adder #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .Cin (Cin),
        .Sum (Sum),
        .Cout(Cout)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                        input logic ci, input string tag);
        logic [4:0] exp;
        logic [4:0] got;
        rst = r;
        A   = a;
        B   = b;
        Cin = ci;
        sb.push_back(r ? 5'd0 : ({1'b0, a} + {1'b0, b} + {4'd0, ci}));
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        got = {Cout, Sum};
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: A=%h B=%h Cin=%b rst=%b got {Cout,Sum}=%b expected %b",
                   tag, a, b, ci, r, got, exp);
        end
    endtask

    initial begin
        step(1'b1, 4'b1111, 4'b1111, 1'b1, "reset_0");
        step(1'b1, 4'b1111, 4'b1111, 1'b1, "reset_1");
        step(1'b0, 4'b1111, 4'b1111, 1'b1, "release_max");
        step(1'b0, 4'b0001, 4'b0000, 1'b0, "one_plus_zero");
        step(1'b0, 4'b1010, 4'b0011, 1'b0, "a_plus_3");
        step(1'b0, 4'b1101, 4'b1010, 1'b1, "d_plus_a_cin");
        step(1'b0, 4'b1111, 4'b0000, 1'b1, "full_ripple");
        step(1'b0, 4'b0000, 4'b0000, 1'b1, "zero_cin");
        step(1'b0, 4'b0111, 4'b0001, 1'b0, "b2b_0");
        step(1'b0, 4'b1000, 4'b1000, 1'b0, "b2b_1");
        step(1'b0, 4'b0101, 4'b1010, 1'b1, "b2b_2");
        step(1'b1, 4'b1110, 4'b0011, 1'b1, "mid_reset");
        step(1'b0, 4'b0110, 4'b0110, 1'b1, "after_reset");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, "zero");
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    step(1'b0, 4'(a), 4'(b), 1'(c), "sweep");
        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ripple_adder.md
Name: ripple_adder

Overview:
- WIDTH-bit binary adder with carry-in and carry-out, built as a chain of 1-bit full-adder cells. Carry ripples from bit 0 to bit WIDTH-1.
- Result is registered on the single system clock, so the block drops into clocked datapaths as a one-cycle arithmetic stage.
- Used as the basic adder primitive of the logic-design library. The default configuration is 4 bits.

Parameters:
- WIDTH, 4, operand and sum width in bits (>= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- Cin  input  1  carry into bit 0.
- Sum  output  WIDTH  registered sum bits.
- Cout  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). No asynchronous reset path.
- Combinational core: WIDTH full-adder cells, one per bit i.
  - c[0] = Cin.
  - s[i] = A[i] ^ B[i] ^ c[i].
  - c[i+1] = (A[i]&B[i]) | (A[i]&c[i]) | (B[i]&c[i]).
  - No carry-lookahead; the carry path is a pure ripple.
- Arithmetic: {Cout, Sum} = A + B + Cin, computed as an unsigned (WIDTH+1)-bit result. Cout is the true carry, not a signed overflow flag.
- Register stage: at each rising clk edge with rst=0, Sum <= s[WIDTH-1:0] and Cout <= c[WIDTH].
- Latency: exactly 1 cycle. Inputs applied before edge N appear on Sum/Cout after edge N.
- Throughput: one new operand set per cycle. No handshake; inputs are sampled every cycle unconditionally.
- Reset:
  - At a rising edge with rst=1, Sum <= 0 and Cout <= 0, regardless of A, B or Cin.
  - Reset mid-operation discards the in-flight result.
  - The first rising edge with rst=0 captures the current inputs normally.
- Power-up: outputs are undefined until the first reset edge. The bench must apply reset first.
- Boundary conditions:
  - All-ones + all-ones + Cin=1 gives Sum = all ones, Cout = 1 (max value 2^(WIDTH+1)-1).
  - All-zero inputs with Cin=1 give Sum = 1, Cout = 0.
  - A = all ones, B = 0, Cin = 1: the carry ripples through every bit, giving Sum = 0, Cout = 1. This is the longest path, and timing closure is on it.
- Outputs change only on clock edges; there are no glitches visible at the ports.
- No X-propagation requirements beyond standard 4-state simulation semantics.

Test Plan:
- Reset: rst=1 for 2 cycles with A=4'b1111, B=4'b1111, Cin=1 -> Sum=4'b0000, Cout=0. Release rst; next edge -> Sum=4'b1111, Cout=1.
- A=4'b0001, B=4'b0000, Cin=0 -> one cycle later Sum=4'b0001, Cout=0.
- A=4'b1010, B=4'b0011, Cin=0 -> one cycle later Sum=4'b1101, Cout=0.
- A=4'b1101, B=4'b1010, Cin=1 -> one cycle later Sum=4'b1000, Cout=1.
- Full ripple: A=4'b1111, B=4'b0000, Cin=1 -> Sum=4'b0000, Cout=1. Then back-to-back new operands every cycle, each result correct exactly 1 cycle later.
- Assert rst mid-stream while operands change -> outputs 0 on that edge. Exhaustive 512-vector sweep (all A, B, Cin) against the reference model A+B+Cin with 1-cycle delay.
